// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: credit-limited word reads into a small FIFO that
// feeds decode, with a drain phase after redirects to discard stale responses.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(BUF_DEPTH - 1);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_inst [BUF_DEPTH];
    logic [31:0]   fifo_pc   [BUF_DEPTH];
    logic [CW:0]   credit_used;
    logic          issue;
    logic          resp;
    logic          push;
    logic          pop;
    logic [31:0]   resp_pc;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = resetn && (state == FETCH) && (credit_used < (CW+1)'(BUF_DEPTH));
    assign imem_addr   = pc;
    assign issue       = imem_req & imem_gnt;
    assign resp        = imem_rvalid & (outstanding != '0);
    assign inst_valid  = (count != '0) && (state == FETCH);
    assign pop         = inst_valid & ~stall & ~redirect_valid;
    assign push        = resp & (state == FETCH) & ~redirect_valid;
    assign outstanding_next = outstanding + CW'(issue) - CW'(resp);

    // In FETCH all in-flight reads are consecutive words ending just below pc,
    // so the oldest one's address is recovered without a separate tag queue.
    assign resp_pc = pc - 32'({outstanding, 2'b00});

    assign inst    = inst_valid ? fifo_inst[rd_ptr] : '0;
    assign inst_pc = inst_valid ? fifo_pc[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (state == FETCH) begin
                if (redirect_valid) begin
                    pc     <= redirect_pc;
                    count  <= '0;
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    state  <= (outstanding_next == '0) ? FETCH : DRAIN;
                end else begin
                    if (issue) pc <= pc + 32'd4;
                    if (push)  wr_ptr <= bump(wr_ptr);
                    if (pop)   rd_ptr <= bump(rd_ptr);
                    count <= count + CW'(push) - CW'(pop);
                end
            end else begin
                // Responses arriving here belong to the abandoned path.
                if (redirect_valid) pc <= redirect_pc;
                if (outstanding_next == '0) state <= FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule
